// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/almost-empty
// thresholds, occupancy count, synchronous flush and read+write pass-through at full.
module sync_fifo_prog #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  if (FIFO_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_prog: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_prog: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : g_bad_af
    $error("sync_fifo_prog: AF_LEVEL out of range 1..FIFO_DEPTH-1");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_prog: AE_LEVEL out of range 1..FIFO_DEPTH-1");
  end

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_acc, wr_acc;

  // A read frees a slot on the same edge, so a full FIFO still accepts a paired write.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    wr_ack_d    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ack_d    = wr_acc;
      overflow_d  = wr_en & ~wr_acc;
      underflow_d = rd_en & ~rd_acc;
      if (wr_acc) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc) begin
        rd_ptr_d   = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        data_out_d = mem_q[rd_ptr_q];
      end
      if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign almostfull  = (count_q >= CW'(AF_LEVEL)) && !full;
  assign almostempty = (count_q <= CW'(AE_LEVEL)) && !empty;
  assign count       = count_q;
  assign data_out    = data_out_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a depth-8 default instance and a
// depth-5 instance with custom thresholds.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  logic        a_flush, a_wr, a_rd;
  logic [15:0] a_din, a_dout;
  logic        a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_count;

  logic        b_flush, b_wr, b_rd;
  logic [15:0] b_din, b_dout;
  logic        b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
    .rd_en(a_rd), .data_out(a_dout), .wr_ack(a_ack), .overflow(a_ovf),
    .underflow(a_udf), .full(a_full), .empty(a_empty), .almostfull(a_af),
    .almostempty(a_ae), .count(a_count)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
    .rd_en(b_rd), .data_out(b_dout), .wr_ack(b_ack), .overflow(b_ovf),
    .underflow(b_udf), .full(b_full), .empty(b_empty), .almostfull(b_af),
    .almostempty(b_ae), .count(b_count)
  );

  // Interleaved depth-5 sequence starting from an empty, flushed FIFO
  localparam int T_WR   [12] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0};
  localparam int T_RD   [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1};
  localparam int T_DIN  [12] = '{'hB0, 'hB1, 'hB2, 'hB3, 'hB4, 0, 0, 'hB5, 0, 0, 0, 0};
  localparam int T_CNT  [12] = '{1, 2, 3, 4, 5, 4, 3, 4, 3, 2, 1, 0};
  localparam int T_DOUT [12] = '{0, 0, 0, 0, 0, 'hB0, 'hB1, 'hB1, 'hB2, 'hB3, 'hB4, 'hB5};
  localparam int T_AF   [12] = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};
  localparam int T_AE   [12] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
  localparam int T_FULL [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  localparam int T_EMP  [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_flush = 0; a_wr = 0; a_rd = 0; a_din = '0;
    b_flush = 0; b_wr = 0; b_rd = 0; b_din = '0;
    #1;
    total_cnt++; if (a_empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", a_empty); else pass_cnt++;
    total_cnt++; if (a_count !== 4'd0) $display("FAIL reset_count got %0d exp 0", a_count); else pass_cnt++;
    total_cnt++; if (a_dout !== 16'h0) $display("FAIL reset_dout got %h exp 0000", a_dout); else pass_cnt++;
    total_cnt++; if ({a_ack, a_ovf, a_udf, a_full, a_af, a_ae} !== 6'b0)
      $display("FAIL reset_flags got %b exp 000000", {a_ack, a_ovf, a_udf, a_full, a_af, a_ae}); else pass_cnt++;
    cyc(); cyc();
    rst_n = 1'b1;
    a_wr = 1;
    for (int k = 1; k <= 5; k++) begin
      a_din = 16'(k);
      cyc();
    end
    a_wr = 0;
    total_cnt++; if (a_count !== 4'd5) $display("FAIL midfill_count got %0d exp 5", a_count); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (a_count !== 4'd0) $display("FAIL async_rst_count got %0d exp 0", a_count); else pass_cnt++;
    total_cnt++; if (a_empty !== 1'b1) $display("FAIL async_rst_empty got %b exp 1", a_empty); else pass_cnt++;
    total_cnt++; if (a_ack !== 1'b0) $display("FAIL async_rst_ack got %b exp 0", a_ack); else pass_cnt++;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    a_wr = 1;
    for (int k = 1; k <= 8; k++) begin
      a_din = 16'(k);
      cyc();
      total_cnt++; if (a_ack !== 1'b1) $display("FAIL fill_ack[%0d] got %b exp 1", k, a_ack); else pass_cnt++;
      total_cnt++; if (a_count !== 4'(k)) $display("FAIL fill_count[%0d] got %0d exp %0d", k, a_count, k); else pass_cnt++;
      total_cnt++; if (a_af !== (k == 7)) $display("FAIL fill_af[%0d] got %b exp %b", k, a_af, (k == 7)); else pass_cnt++;
      total_cnt++; if (a_full !== (k == 8)) $display("FAIL fill_full[%0d] got %b exp %b", k, a_full, (k == 8)); else pass_cnt++;
    end
    a_din = 16'h0009;
    cyc();
    a_wr = 0;
    total_cnt++; if (a_ovf !== 1'b1) $display("FAIL ovf_flag got %b exp 1", a_ovf); else pass_cnt++;
    total_cnt++; if (a_ack !== 1'b0) $display("FAIL ovf_ack got %b exp 0", a_ack); else pass_cnt++;
    total_cnt++; if (a_count !== 4'd8) $display("FAIL ovf_count got %0d exp 8", a_count); else pass_cnt++;
  endtask

  task automatic test_drain();
    a_rd = 1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      total_cnt++; if (a_dout !== 16'(k)) $display("FAIL drain_dout[%0d] got %h exp %h", k, a_dout, 16'(k)); else pass_cnt++;
      total_cnt++; if (a_count !== 4'(8 - k)) $display("FAIL drain_count[%0d] got %0d exp %0d", k, a_count, 8 - k); else pass_cnt++;
      total_cnt++; if (a_ae !== (k == 7)) $display("FAIL drain_ae[%0d] got %b exp %b", k, a_ae, (k == 7)); else pass_cnt++;
      total_cnt++; if (a_empty !== (k == 8)) $display("FAIL drain_empty[%0d] got %b exp %b", k, a_empty, (k == 8)); else pass_cnt++;
    end
    cyc();
    a_rd = 0;
    total_cnt++; if (a_udf !== 1'b1) $display("FAIL udf_flag got %b exp 1", a_udf); else pass_cnt++;
    total_cnt++; if (a_dout !== 16'h0008) $display("FAIL udf_dout got %h exp 0008", a_dout); else pass_cnt++;
    total_cnt++; if (a_count !== 4'd0) $display("FAIL udf_count got %0d exp 0", a_count); else pass_cnt++;
  endtask

  task automatic test_full_rw();
    a_wr = 1;
    for (int k = 0; k < 8; k++) begin
      a_din = 16'(16'h0010 + k);
      cyc();
    end
    total_cnt++; if (a_full !== 1'b1) $display("FAIL prefill_full got %b exp 1", a_full); else pass_cnt++;
    a_rd = 1; a_din = 16'hAAAA;
    cyc();
    a_wr = 0;
    total_cnt++; if (a_ack !== 1'b1) $display("FAIL fullrw_ack got %b exp 1", a_ack); else pass_cnt++;
    total_cnt++; if (a_ovf !== 1'b0) $display("FAIL fullrw_ovf got %b exp 0", a_ovf); else pass_cnt++;
    total_cnt++; if (a_count !== 4'd8) $display("FAIL fullrw_count got %0d exp 8", a_count); else pass_cnt++;
    total_cnt++; if (a_dout !== 16'h0010) $display("FAIL fullrw_dout got %h exp 0010", a_dout); else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) begin
        total_cnt++; if (a_dout !== 16'h0011) $display("FAIL wrap_first got %h exp 0011", a_dout); else pass_cnt++;
      end
    end
    a_rd = 0;
    total_cnt++; if (a_dout !== 16'hAAAA) $display("FAIL wrap_last got %h exp aaaa", a_dout); else pass_cnt++;
    total_cnt++; if (a_empty !== 1'b1) $display("FAIL wrap_empty got %b exp 1", a_empty); else pass_cnt++;
  endtask

  task automatic test_empty_rw();
    a_wr = 1; a_rd = 1; a_din = 16'h1234;
    cyc();
    a_wr = 0;
    total_cnt++; if (a_count !== 4'd1) $display("FAIL emptyrw_count got %0d exp 1", a_count); else pass_cnt++;
    total_cnt++; if (a_udf !== 1'b1) $display("FAIL emptyrw_udf got %b exp 1", a_udf); else pass_cnt++;
    total_cnt++; if (a_ack !== 1'b1) $display("FAIL emptyrw_ack got %b exp 1", a_ack); else pass_cnt++;
    total_cnt++; if (a_dout !== 16'hAAAA) $display("FAIL emptyrw_hold got %h exp aaaa", a_dout); else pass_cnt++;
    cyc();
    a_rd = 0;
    total_cnt++; if (a_dout !== 16'h1234) $display("FAIL emptyrw_read got %h exp 1234", a_dout); else pass_cnt++;
    total_cnt++; if (a_count !== 3'd0) $display("FAIL emptyrw_count2 got %0d exp 0", a_count); else pass_cnt++;
  endtask

  task automatic test_flush();
    b_wr = 1;
    for (int k = 0; k < 4; k++) begin
      b_din = 16'(16'h0050 + k);
      cyc();
    end
    total_cnt++; if (b_count !== 3'd4) $display("FAIL preflush_count got %0d exp 4", b_count); else pass_cnt++;
    total_cnt++; if (b_af !== 1'b1) $display("FAIL preflush_af got %b exp 1", b_af); else pass_cnt++;
    b_flush = 1; b_din = 16'hFFFF;
    cyc();
    b_flush = 0; b_wr = 0;
    total_cnt++; if (b_count !== 3'd0) $display("FAIL flush_count got %0d exp 0", b_count); else pass_cnt++;
    total_cnt++; if (b_empty !== 1'b1) $display("FAIL flush_empty got %b exp 1", b_empty); else pass_cnt++;
    total_cnt++; if (b_ack !== 1'b0) $display("FAIL flush_ack got %b exp 0", b_ack); else pass_cnt++;
    total_cnt++; if (b_af !== 1'b0) $display("FAIL flush_af got %b exp 0", b_af); else pass_cnt++;
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 12; i++) begin
      b_wr = T_WR[i][0]; b_rd = T_RD[i][0]; b_din = 16'(T_DIN[i]);
      cyc();
      total_cnt++; if (b_count !== 3'(T_CNT[i])) $display("FAIL il_count[%0d] got %0d exp %0d", i, b_count, T_CNT[i]); else pass_cnt++;
      total_cnt++; if (b_dout !== 16'(T_DOUT[i])) $display("FAIL il_dout[%0d] got %h exp %h", i, b_dout, 16'(T_DOUT[i])); else pass_cnt++;
      total_cnt++; if (b_af !== T_AF[i][0]) $display("FAIL il_af[%0d] got %b exp %0d", i, b_af, T_AF[i]); else pass_cnt++;
      total_cnt++; if (b_ae !== T_AE[i][0]) $display("FAIL il_ae[%0d] got %b exp %0d", i, b_ae, T_AE[i]); else pass_cnt++;
      total_cnt++; if (b_full !== T_FULL[i][0]) $display("FAIL il_full[%0d] got %b exp %0d", i, b_full, T_FULL[i]); else pass_cnt++;
      total_cnt++; if (b_empty !== T_EMP[i][0]) $display("FAIL il_empty[%0d] got %b exp %0d", i, b_empty, T_EMP[i]); else pass_cnt++;
    end
    b_wr = 0; b_rd = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_flush();
    test_interleave();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
